branch_pred_ctrl: RTL and testbench
===================================

Name: branch_pred_ctrl

Overview:
- Branch prediction controller that drives the PC-select mux.
- Holds a 2-bit saturating branch history table (BHT) indexed by IF-stage PC.
- Queues one prediction record per in-flight B-type from IF until it resolves in EXE.
- On resolution, flags mispredictions and supplies the recovery PC (PC_imm_que) and pipeline flush.

Parameters:
- DATA_W, 32, PC/data width (matches `data_size).
- BHT_IDX_W, 4, BHT index bits; table depth 2**BHT_IDX_W; index = PC_IF[BHT_IDX_W+1:2].
- QUE_DEPTH, 2, prediction-queue entries (IF->EXE distance); power of 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- PC_IF  in  DATA_W  PC of instruction in IF.
- opcode_IF  in  7  IF opcode.
- PC_added  in  DATA_W  PC_IF+4.
- PC_imm  in  DATA_W  PC_IF+imm (branch target).
- opcode_EXE  in  7  EXE opcode.
- br_taken_EXE  in  1  actual branch outcome in EXE, valid when opcode_EXE==`Btype.
- Istall  in  1  instruction-memory stall.
- Dstall  in  1  data-memory stall.
- taken_sel  out  1  IF prediction: 1 = redirect to PC_imm.
- jump_sel  out  1  EXE actual outcome (br_taken_EXE gated by Btype_EXE).
- PC_imm_que  out  DATA_W  recovery PC of queue head.
- flush  out  1  misprediction, kill IF/ID.
- que_full  out  1  occupancy == QUE_DEPTH.
- que_empty  out  1  occupancy == 0.
- err_ovf  out  1  one-cycle pulse, push dropped on full.
- err_udf  out  1  one-cycle pulse, EXE branch with empty queue.
- br_cnt  out  16  resolved branches, wraps.
- miss_cnt  out  16  mispredictions, wraps.

Behaviour:
- Reset (rst=0, async):
  - All BHT counters = 2'b01 (weakly not-taken).
  - Queue empty; rd/wr pointers = 0.
  - br_cnt = miss_cnt = 0.
  - err_ovf = err_udf = 0.
  - Reset mid-operation discards all queued records immediately.
- stall = Istall|Dstall. While stall = 1, no push, pop, BHT update or counter increment. Combinational outputs still evaluate; flush is forced to 0.
- IF prediction (combinational):
  - Jtype: taken_sel = 1; no push.
  - Btype: taken_sel = BHT[idx][1].
  - Otherwise: taken_sel = 0.
- Push (edge, Btype_IF & !stall & !flush): write record {pred=taken_sel, idx, rec_pc = taken_sel ? PC_added : PC_imm}.
- EXE resolution (combinational, Btype_EXE & !que_empty):
  - mis = head.pred ^ br_taken_EXE.
  - flush = mis & !stall.
  - PC_imm_que = head.rec_pc.
- When not resolving: PC_imm_que = head.rec_pc if non-empty, else 0; flush = 0.
- Pop/update (edge, Btype_EXE & !stall & !que_empty):
  - Pop head.
  - BHT[head.idx]: taken -> saturating increment (max 2'b11); not-taken -> saturating decrement (min 2'b00).
  - br_cnt += 1; miss_cnt += mis.
- Flush edge: queue cleared after the pop (younger records are wrong-path); same-cycle push suppressed.
- Simultaneous push and pop (no flush): both occur; occupancy unchanged; legal when full.
- Full & push & no pop: push dropped, err_ovf pulses.
- Empty & Btype_EXE & !stall:
  - err_udf pulses.
  - No BHT update.
  - flush = 0; jump_sel still = br_taken_EXE.
- BHT read/write same index same cycle: read returns the pre-update value.
- Pointers wrap modulo QUE_DEPTH; occupancy counter is log2(QUE_DEPTH)+1 bits.
- Latency: prediction 0 cycles; flush 0 cycles after EXE resolve; BHT update visible the next cycle.

Test Plan:
- Reset, then Btype at PC 0x40 in IF -> taken_sel=0; push rec_pc=PC_imm (0x80); que_empty=0 next cycle.
- Same branch resolves taken in EXE twice (no stall) -> flush=1 and PC_imm_que=0x80 on first; BHT[0] goes 01->10->11; third fetch at 0x40 gives taken_sel=1, rec_pc=0x44.
- Counter at 11, branch resolves not-taken -> flush=1, PC_imm_que=0x44, counter=10, miss_cnt increments, queued younger record cleared, same-cycle IF push dropped.
- Queue full (2 entries), Btype in IF and EXE same cycle -> occupancy stays 2, no err_ovf; repeat without EXE branch -> err_ovf pulses 1 cycle.
- Mispredicting branch in EXE while Dstall=1 for 3 cycles -> flush=0, queue/BHT frozen; on stall release flush=1 for exactly one cycle.
- Btype_EXE with empty queue -> err_udf=1, flush=0, br_cnt unchanged; assert rst low mid-stream -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/branch_pred_ctrl.sv
// Branch prediction controller: 2-bit BHT lookup in IF, in-flight
// prediction queue, EXE-side misprediction detection and recovery.
module branch_pred_ctrl #(
  parameter int DATA_W    = 32,
  parameter int BHT_IDX_W = 4,
  parameter int QUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] PC_IF,
  input  logic [6:0]        opcode_IF,
  input  logic [DATA_W-1:0] PC_added,
  input  logic [DATA_W-1:0] PC_imm,
  input  logic [6:0]        opcode_EXE,
  input  logic              br_taken_EXE,
  input  logic              Istall,
  input  logic              Dstall,
  output logic              taken_sel,
  output logic              jump_sel,
  output logic [DATA_W-1:0] PC_imm_que,
  output logic              flush,
  output logic              que_full,
  output logic              que_empty,
  output logic              err_ovf,
  output logic              err_udf,
  output logic [15:0]       br_cnt,
  output logic [15:0]       miss_cnt
);

  localparam logic [6:0] BTYPE = 7'b1100011;
  localparam logic [6:0] JTYPE = 7'b1101111;
  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int PW = $clog2(QUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QUE_DEPTH);

  typedef struct packed {
    logic                 pred;
    logic [BHT_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    rec_pc;
  } rec_t;

  logic [1:0]    bht [BHT_N];
  rec_t          que [QUE_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] occ;

  logic                 stall;
  logic                 btype_if;
  logic                 jtype_if;
  logic                 btype_exe;
  logic [BHT_IDX_W-1:0] idx_if;
  rec_t                 head;
  logic                 resolve;
  logic                 mis;
  logic                 pop;
  logic                 push_req;
  logic                 push;
  logic                 unused;

  assign stall     = Istall | Dstall;
  assign btype_if  = (opcode_IF == BTYPE);
  assign jtype_if  = (opcode_IF == JTYPE);
  assign btype_exe = (opcode_EXE == BTYPE);
  assign idx_if    = PC_IF[BHT_IDX_W+1:2];
  assign unused    = ^{PC_IF[DATA_W-1:BHT_IDX_W+2],
                       PC_IF[1:0]};

  always_comb begin
    taken_sel = 1'b0;
    unique case (1'b1)
      jtype_if: taken_sel = 1'b1;
      btype_if: taken_sel = bht[idx_if][1];
      default:  taken_sel = 1'b0;
    endcase
  end

  assign head      = que[rd_ptr];
  assign que_empty = (occ == '0);
  assign que_full  = (occ == FULL_CNT);
  assign resolve   = btype_exe & ~que_empty;
  assign mis       = resolve & (head.pred ^ br_taken_EXE);
  assign flush     = mis & ~stall;
  assign jump_sel  = btype_exe & br_taken_EXE;
  assign PC_imm_que = que_empty ? '0 : head.rec_pc;

  // A pop frees a slot in the same cycle, so push is legal when full
  assign pop      = resolve & ~stall;
  assign push_req = btype_if & ~stall & ~flush;
  assign push     = push_req & (~que_full | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      que[wr_ptr].pred   <= taken_sel;
      que[wr_ptr].idx    <= idx_if;
      que[wr_ptr].rec_pc <= taken_sel ? PC_added : PC_imm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      br_cnt   <= '0;
      miss_cnt <= '0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
    end else begin
      err_ovf <= push_req & ~push;
      err_udf <= btype_exe & que_empty & ~stall;
      if (pop) begin
        if (br_taken_EXE && bht[head.idx] != 2'b11)
          bht[head.idx] <= bht[head.idx] + 2'd1;
        else if (!br_taken_EXE && bht[head.idx] != 2'b00)
          bht[head.idx] <= bht[head.idx] - 2'd1;
        br_cnt   <= br_cnt + 16'd1;
        miss_cnt <= miss_cnt + 16'(mis);
      end
      // Records younger than a mispredicted branch are wrong-path
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Bench for branch_pred_ctrl: queue/array reference model checked
// every cycle plus directed literal expectations.
module tb_branch_pred_ctrl;

  localparam logic [6:0] B = 7'b1100011;
  localparam logic [6:0] J = 7'b1101111;
  localparam logic [6:0] N = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC_IF = '0;
  logic [6:0]  opcode_IF = N;
  logic [31:0] PC_added = 32'd4;
  logic [31:0] PC_imm = 32'h40;
  logic [6:0]  opcode_EXE = N;
  logic        br_taken_EXE = 1'b0;
  logic        Istall = 1'b0;
  logic        Dstall = 1'b0;
  logic        taken_sel;
  logic        jump_sel;
  logic [31:0] PC_imm_que;
  logic        flush;
  logic        que_full;
  logic        que_empty;
  logic        err_ovf;
  logic        err_udf;
  logic [15:0] br_cnt;
  logic [15:0] miss_cnt;

  branch_pred_ctrl dut (
    .clk(clk), .rst(rst), .PC_IF(PC_IF),
    .opcode_IF(opcode_IF), .PC_added(PC_added),
    .PC_imm(PC_imm), .opcode_EXE(opcode_EXE),
    .br_taken_EXE(br_taken_EXE), .Istall(Istall),
    .Dstall(Dstall), .taken_sel(taken_sel),
    .jump_sel(jump_sel), .PC_imm_que(PC_imm_que),
    .flush(flush), .que_full(que_full),
    .que_empty(que_empty), .err_ovf(err_ovf),
    .err_udf(err_udf), .br_cnt(br_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  typedef struct {
    bit          pred;
    int          idx;
    logic [31:0] rec;
  } mrec_t;

  mrec_t mq[$];
  int    m_bht[16];
  int    m_br;
  int    m_miss;
  bit    m_ovf;
  bit    m_udf;

  function automatic int if_idx();
    return int'((PC_IF >> 2) & 32'hf);
  endfunction

  function automatic bit m_taken();
    if (opcode_IF == J) return 1'b1;
    if (opcode_IF == B) return m_bht[if_idx()] >= 2;
    return 1'b0;
  endfunction

  function automatic bit m_mis();
    if (opcode_EXE != B || mq.size() == 0) return 1'b0;
    return mq[0].pred != br_taken_EXE;
  endfunction

  bit u_tk;
  bit u_mis;
  int u_ix;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_br = 0;
      m_miss = 0;
      m_ovf = 0;
      m_udf = 0;
    end else if (Istall || Dstall) begin
      m_ovf = 0;
      m_udf = 0;
    end else begin
      u_tk = m_taken();
      u_mis = m_mis();
      m_ovf = 0;
      m_udf = (opcode_EXE == B) && mq.size() == 0;
      if (opcode_EXE == B && mq.size() > 0) begin
        u_ix = mq[0].idx;
        if (br_taken_EXE)
          m_bht[u_ix] = (m_bht[u_ix] < 3) ? m_bht[u_ix] + 1 : 3;
        else
          m_bht[u_ix] = (m_bht[u_ix] > 0) ? m_bht[u_ix] - 1 : 0;
        void'(mq.pop_front());
        m_br++;
        if (u_mis) m_miss++;
      end
      if (u_mis) mq.delete();
      else if (opcode_IF == B) begin
        if (mq.size() < 2)
          mq.push_back('{u_tk, if_idx(),
                         u_tk ? PC_added : PC_imm});
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_taken", taken_sel, m_taken());
    chk("m_jump", jump_sel, opcode_EXE == B && br_taken_EXE);
    chk("m_pcq", PC_imm_que, mq.size() ? mq[0].rec : 0);
    chk("m_flush", flush,
        m_mis() && !(Istall || Dstall));
    chk("m_full", que_full, mq.size() == 2);
    chk("m_empty", que_empty, mq.size() == 0);
    chk("m_ovf", err_ovf, m_ovf);
    chk("m_udf", err_udf, m_udf);
    chk("m_br", br_cnt, m_br & 16'hffff);
    chk("m_miss", miss_cnt, m_miss & 16'hffff);
  end

  task automatic drv(logic [6:0] oi, logic [31:0] pc,
                     logic [6:0] oe, logic tk,
                     logic ist, logic dst);
    opcode_IF = oi;
    PC_IF = pc;
    PC_added = pc + 32'd4;
    PC_imm = pc + 32'h40;
    opcode_EXE = oe;
    br_taken_EXE = tk;
    Istall = ist;
    Dstall = dst;
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(N, 0, N, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", que_empty, 1);
    chk("rst_br", br_cnt, 0);
    chk("rst_ovf", err_ovf, 0);
    rst = 1'b1;

    drv(B, 'h40, N, 0, 0, 0);
    chk("a_taken", taken_sel, 0);
    nxt();
    chk("a_empty", que_empty, 0);
    chk("a_pcq", PC_imm_que, 'h80);

    drv(N, 0, B, 1, 0, 0);
    chk("b_flush", flush, 1);
    chk("b_pcq", PC_imm_que, 'h80);
    nxt();
    chk("b_br", br_cnt, 1);
    chk("b_miss", miss_cnt, 1);

    drv(B, 'h40, N, 0, 0, 0);
    chk("c_taken", taken_sel, 1);
    nxt();
    drv(N, 0, B, 1, 0, 0);
    chk("d_flush", flush, 0);
    nxt();
    chk("d_miss", miss_cnt, 1);

    drv(B, 'h40, N, 0, 0, 0);
    chk("e_taken", taken_sel, 1);
    nxt();
    chk("e_pcq", PC_imm_que, 'h44);
    drv(B, 'h44, N, 0, 0, 0);
    chk("f_taken", taken_sel, 0);
    nxt();
    chk("f_full", que_full, 1);

    drv(B, 'h48, B, 0, 0, 0);
    chk("g_flush", flush, 1);
    chk("g_pcq", PC_imm_que, 'h44);
    nxt();
    chk("g_empty", que_empty, 1);
    chk("g_miss", miss_cnt, 2);

    drv(B, 'h40, N, 0, 0, 0);
    nxt();
    drv(B, 'h50, N, 0, 0, 0);
    nxt();
    chk("i_full", que_full, 1);
    drv(B, 'h60, B, 1, 0, 0);
    chk("j_flush", flush, 0);
    nxt();
    chk("j_full", que_full, 1);
    chk("j_ovf", err_ovf, 0);
    chk("j_pcq", PC_imm_que, 'h90);
    drv(B, 'h70, N, 0, 0, 0);
    nxt();
    chk("k_ovf", err_ovf, 1);
    drv(N, 0, N, 0, 0, 0);
    nxt();
    chk("l_ovf", err_ovf, 0);

    drv(N, 0, B, 1, 0, 1);
    chk("m_stall_flush", flush, 0);
    repeat (3) nxt();
    chk("m_stall_br", br_cnt, 4);
    drv(N, 0, B, 1, 1, 0);
    chk("m_istall_flush", flush, 0);
    nxt();
    drv(N, 0, B, 1, 0, 0);
    chk("n_flush", flush, 1);
    chk("n_pcq", PC_imm_que, 'h90);
    nxt();
    chk("n_br", br_cnt, 5);
    drv(N, 0, N, 0, 0, 0);
    chk("o_flush", flush, 0);

    drv(N, 0, B, 1, 0, 0);
    chk("p_flush", flush, 0);
    chk("p_jump", jump_sel, 1);
    nxt();
    chk("p_udf", err_udf, 1);
    chk("p_br", br_cnt, 5);
    drv(N, 0, N, 0, 0, 0);
    nxt();
    chk("q_udf", err_udf, 0);

    drv(J, 'h20, N, 0, 0, 0);
    chk("j_taken", taken_sel, 1);
    nxt();
    chk("j_empty", que_empty, 1);
    drv(B, 'h40, N, 0, 0, 0);
    nxt();
    chk("r_empty", que_empty, 0);

    drv(N, 0, N, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("ar_empty", que_empty, 1);
    chk("ar_br", br_cnt, 0);
    chk("ar_pcq", PC_imm_que, 0);
    drv(B, 'h40, N, 0, 0, 0);
    chk("ar_taken", taken_sel, 0);
    nxt();
    rst = 1'b1;
    drv(N, 0, N, 0, 0, 0);
    repeat (2) nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
